// File: rtl/b2c_nib2ser_pkg.sv
// b2c_pkg: shared widths and FSM state type for the nibble-to-serial packer.
// No ports; imported by b2c_nib2ser_if, b2c_shift_reg and b2c_nib2ser.
package b2c_pkg;

  localparam int NIB_W      = 4;
  localparam int NIB_NUM    = 16;
  localparam int FRAME_BITS = NIB_W * NIB_NUM;
  localparam int NIB_CNT_W  = $clog2(NIB_NUM);
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/b2c_nib2ser_if.sv
// b2c_nib2ser_if: nibble input handshake and serial output bundle.
// master = nibble source / serial sink, slave = the packer.
interface b2c_nib2ser_if;
  import b2c_pkg::*;

  logic [NIB_W-1:0] b2c_in;
  logic             b2c_in_vld;
  logic             b2c_in_rdy;
  logic             b2c_out;
  logic             b2c_out_vld;
  logic             b2c_out_last;
  logic             b2c_over;

  modport master (
    output b2c_in,
    output b2c_in_vld,
    input  b2c_in_rdy,
    input  b2c_out,
    input  b2c_out_vld,
    input  b2c_out_last,
    input  b2c_over
  );

  modport slave (
    input  b2c_in,
    input  b2c_in_vld,
    output b2c_in_rdy,
    output b2c_out,
    output b2c_out_vld,
    output b2c_out_last,
    output b2c_over
  );

endinterface

// File: rtl/b2c_nib2ser_shift_reg.sv
// b2c_shift_reg: frame register with indexed nibble load and 1-bit shift.
// Ports: clk, clr_i (sync clear), ld_i/idx_i/nib_i (nibble write),
// sh_i (shift one bit), head_o (bit due now), next_o (bit due after shift).
// B2C_LSB_FIRST_EN: nibble k at [4k+3:4k], bit 0 leaves first;
// otherwise nibble k at [63-4k:60-4k], bit 63 leaves first.
module b2c_shift_reg
  import b2c_pkg::*;
(
  input  logic                 clk,
  input  logic                 clr_i,
  input  logic                 ld_i,
  input  logic [NIB_CNT_W-1:0] idx_i,
  input  logic [NIB_W-1:0]     nib_i,
  input  logic                 sh_i,
  output logic                 head_o,
  output logic                 next_o
);

  logic [FRAME_BITS-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (ld_i) begin
      for (int k = 0; k < NIB_NUM; k++) begin
        if (idx_i == NIB_CNT_W'(k)) begin
`ifdef B2C_LSB_FIRST_EN
          sr_d[NIB_W*k +: NIB_W] = nib_i;
`else
          sr_d[FRAME_BITS-NIB_W*(k+1) +: NIB_W] = nib_i;
`endif
        end
      end
    end else if (sh_i) begin
`ifdef B2C_LSB_FIRST_EN
      sr_d = {1'b0, sr_q[FRAME_BITS-1:1]};
`else
      sr_d = {sr_q[FRAME_BITS-2:0], 1'b0};
`endif
    end
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

`ifdef B2C_LSB_FIRST_EN
  assign head_o = sr_q[0];
  assign next_o = sr_q[1];
`else
  assign head_o = sr_q[FRAME_BITS-1];
  assign next_o = sr_q[FRAME_BITS-2];
`endif

endmodule

// File: rtl/b2c_nib2ser.sv
// b2c_nib2ser: packs 16 nibbles into a 64-bit frame, then emits it serially.
// Ports: clk, rst (sync, active-high), b2c_en (low = clear), bus (slave).
// Config macro B2C_LSB_FIRST_EN selects LSB-first packing and shifting.
module b2c_nib2ser
  import b2c_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          b2c_en,
  b2c_nib2ser_if.slave  bus
);

  state_e               state_q, state_d;
  logic [NIB_CNT_W-1:0] nib_cnt_q, nib_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 rdy_q, rdy_d;
  logic                 out_q, out_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic                 over_q, over_d;

  logic clr;
  logic ld;
  logic sh;
  logic head;
  logic next;

  assign clr = rst | ~b2c_en;

  b2c_shift_reg u_sr (
    .clk    (clk),
    .clr_i  (clr),
    .ld_i   (ld),
    .idx_i  (nib_cnt_q),
    .nib_i  (bus.b2c_in),
    .sh_i   (sh),
    .head_o (head),
    .next_o (next)
  );

  always_comb begin
    state_d   = state_q;
    nib_cnt_d = nib_cnt_q;
    bit_cnt_d = bit_cnt_q;
    rdy_d     = 1'b0;
    out_d     = 1'b0;
    vld_d     = 1'b0;
    last_d    = 1'b0;
    over_d    = 1'b0;
    ld        = 1'b0;
    sh        = 1'b0;
    if (clr) begin
      state_d   = IDLE;
      nib_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = LOAD;
          rdy_d   = 1'b1;
        end
        LOAD: begin
          rdy_d = 1'b1;
          if (bus.b2c_in_vld && rdy_q) begin
            ld = 1'b1;
            if (nib_cnt_q == NIB_CNT_W'(NIB_NUM-1)) begin
              // Nibble 0 already holds the first bit, so it can be
              // registered on the same edge the last nibble lands.
              state_d   = SHIFT;
              rdy_d     = 1'b0;
              out_d     = head;
              vld_d     = 1'b1;
              bit_cnt_d = '0;
            end else begin
              nib_cnt_d = nib_cnt_q + 1'b1;
            end
          end
        end
        SHIFT: begin
          if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS-1)) begin
            state_d = DONE;
            over_d  = 1'b1;
          end else begin
            sh        = 1'b1;
            out_d     = next;
            vld_d     = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            last_d    = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS-2));
          end
        end
        DONE: begin
          over_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nib_cnt_q <= '0;
      bit_cnt_q <= '0;
      rdy_q     <= 1'b0;
      out_q     <= 1'b0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_cnt_q <= nib_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      rdy_q     <= rdy_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      over_q    <= over_d;
    end
  end

  assign bus.b2c_in_rdy   = rdy_q;
  assign bus.b2c_out      = out_q;
  assign bus.b2c_out_vld  = vld_q;
  assign bus.b2c_out_last = last_q;
  assign bus.b2c_over     = over_q;

endmodule

// File: tb/tb_b2c_nib2ser.sv
// tb_b2c_nib2ser: directed + random frames for b2c_nib2ser.
// Reference packs nibbles into a 64-bit word and reads bits in order.
module tb_b2c_nib2ser;
  import b2c_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  b2c_nib2ser_if bus ();

  b2c_nib2ser dut (
    .clk    (clk),
    .rst    (rst),
    .b2c_en (en),
    .bus    (bus)
  );

  int errs   = 0;
  int checks = 0;

  logic [3:0]  nq [16];
  logic [63:0] capt;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_frame();
    logic [63:0] f;
    f = '0;
    for (int k = 0; k < 16; k++) begin
`ifdef B2C_LSB_FIRST_EN
      f = f | (64'(nq[k]) << (4 * k));
`else
      f = f | (64'(nq[k]) << (60 - 4 * k));
`endif
    end
    return f;
  endfunction

  function automatic logic model_bit(input logic [63:0] f, input int i);
`ifdef B2C_LSB_FIRST_EN
    return f[i];
`else
    return f[63 - i];
`endif
  endfunction

  task automatic chk_quiet(input string tag, input logic over_exp);
    chk({tag, "_rdy"},  bus.b2c_in_rdy,   1'b0);
    chk({tag, "_vld"},  bus.b2c_out_vld,  1'b0);
    chk({tag, "_out"},  bus.b2c_out,      1'b0);
    chk({tag, "_last"}, bus.b2c_out_last, 1'b0);
    chk({tag, "_over"}, bus.b2c_over,     over_exp);
  endtask

  // mode: 0 back-to-back, 1 vld every other clk, 2 random gaps
  task automatic load(input int n, input int mode);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 200) begin
      bus.b2c_in = nq[got];
      case (mode)
        1:       bus.b2c_in_vld = (cyc % 2 == 0);
        2:       bus.b2c_in_vld = 1'($urandom_range(0, 1));
        default: bus.b2c_in_vld = 1'b1;
      endcase
      chk("ld_rdy", bus.b2c_in_rdy, 1'b1);
      if (bus.b2c_in_vld && bus.b2c_in_rdy) got++;
      tick();
      cyc++;
    end
    bus.b2c_in_vld = 1'b0;
    bus.b2c_in     = '0;
    chk("ld_count", 64'(got), 64'(n));
  endtask

  task automatic shift(input int nbits);
    logic [63:0] f;
    f    = model_frame();
    capt = '0;
    for (int i = 0; i < nbits; i++) begin
      chk("sh_vld",  bus.b2c_out_vld,  1'b1);
      chk("sh_bit",  bus.b2c_out,      model_bit(f, i));
      chk("sh_last", bus.b2c_out_last, (i == 63));
      chk("sh_rdy",  bus.b2c_in_rdy,   1'b0);
      chk("sh_over", bus.b2c_over,     1'b0);
`ifdef B2C_LSB_FIRST_EN
      capt[i] = bus.b2c_out;
`else
      capt[63 - i] = bus.b2c_out;
`endif
      tick();
    end
  endtask

  task automatic full_frame(input int mode);
    load(16, mode);
    shift(64);
    chk_quiet("done", 1'b1);
    chk("frame", capt, model_frame());
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    chk_quiet("clr", 1'b0);
    en = 1'b1;
    tick();
    chk("rst_rdy", bus.b2c_in_rdy, 1'b1);
  endtask

  task automatic rand_nibs();
    for (int k = 0; k < 16; k++) nq[k] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    rst            = 1'b1;
    en             = 1'b0;
    bus.b2c_in     = '0;
    bus.b2c_in_vld = 1'b0;
    tick();
    tick();
    chk_quiet("reset", 1'b0);

    // rst and en together: rst wins
    en = 1'b1;
    tick();
    chk("rst_wins_rdy", bus.b2c_in_rdy, 1'b0);
    rst = 1'b0;
    tick();
    chk("en_rdy", bus.b2c_in_rdy, 1'b1);

    // 1: descending nibbles back-to-back
    for (int k = 0; k < 16; k++) nq[k] = 4'(15 - k);
    full_frame(0);
`ifndef B2C_LSB_FIRST_EN
    chk("t1_const", capt, 64'hFEDC_BA98_7654_3210);
`endif

    // 2: same frame, vld every other clk
    restart();
    full_frame(1);
`ifndef B2C_LSB_FIRST_EN
    chk("t2_const", capt, 64'hFEDC_BA98_7654_3210);
`endif

    // 3: rst after 7 nibbles, then 0xA frame
    restart();
    rand_nibs();
    load(7, 0);
    rst = 1'b1;
    tick();
    chk_quiet("t3_rst", 1'b0);
    rst = 1'b0;
    tick();
    chk("t3_rdy", bus.b2c_in_rdy, 1'b1);
    for (int k = 0; k < 16; k++) nq[k] = 4'hA;
    full_frame(0);
`ifndef B2C_LSB_FIRST_EN
    chk("t3_const", capt, {32{2'b10}});
`endif

    // 4: en low at bit 30 of shift, then fresh random frame
    restart();
    rand_nibs();
    load(16, 2);
    shift(30);
    en = 1'b0;
    tick();
    chk_quiet("t4_abort", 1'b0);
    en = 1'b1;
    tick();
    chk("t4_rdy", bus.b2c_in_rdy, 1'b1);
    rand_nibs();
    full_frame(2);

    // 5: vld held in DONE is ignored
    bus.b2c_in     = 4'h5;
    bus.b2c_in_vld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_quiet("t5_done", 1'b1);
    end
    bus.b2c_in_vld = 1'b0;
    bus.b2c_in     = '0;

    // 6: single 0x1 nibble then zeros
    restart();
    nq[0] = 4'h1;
    for (int k = 1; k < 16; k++) nq[k] = 4'h0;
    full_frame(0);
`ifdef B2C_LSB_FIRST_EN
    chk("t6_const", capt, 64'h1);
`else
    chk("t6_const", capt, 64'h1000_0000_0000_0000);
`endif

    // extra random frames
    for (int r = 0; r < 3; r++) begin
      restart();
      rand_nibs();
      full_frame(r % 3);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
